tt_serial_addsub: RTL and testbench
===================================

Name: tt_serial_addsub

Overview:
Parametrised bit-serial adder/subtractor. It generalises a 1-bit NAND full adder to WIDTH-bit operands, with add and subtract modes, a registered carry and a start/done handshake. One full-adder cell is reused LSB-first, one bit per clock. It sits behind the tt_um_* top wrapper: operands come from ui_in/uio_in, results go to uo_out.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when busy=0.
op_sub  input  1  0=add (a+b), 1=subtract (a-b); captured with start.
a  input  WIDTH  operand A; captured with start.
b  input  WIDTH  operand B; captured with start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle completion pulse.
sum  output  WIDTH  result; held until the next completion.
carry_out  output  1  add: unsigned carry; sub: 1 = no borrow (a>=b unsigned).
overflow  output  1  two's-complement overflow of the operation.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0; shift registers, carry FF and counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 -> load sh_a=a, sh_b=(op_sub ? ~b : b), carry FF=op_sub, cnt=0; go to RUN.
- RUN: each edge does the following:
  - fa_cell(sh_a[0], sh_b[0], carry) produces s and c.
  - s shifts into the MSB of the result shift register; sh_a and sh_b shift right; carry FF takes c; cnt increments.
  - On the edge where cnt==WIDTH-1, the carry into the MSB (the current carry FF value) is also saved for overflow.
- RUN->DONE at edge E0+WIDTH, i.e. after exactly WIDTH processing edges. At that edge:
  - sum takes the completed result.
  - carry_out takes the final c.
  - overflow = final c XOR carry-into-MSB.
  - done goes to 1.
- DONE: lasts one cycle. done=1, busy=0. Next edge -> IDLE, done=0.
- Start during DONE is accepted exactly as in IDLE (go to RUN, load). This allows back-to-back operations with WIDTH+1 cycles per operation.
- busy=1 exactly while state==RUN, i.e. for WIDTH cycles after E0.
- start while busy=1 is ignored. Operand, op_sub and result registers do not change.
- sum, carry_out and overflow change only at a completion edge. They stay stable during RUN of a following operation.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-RUN aborts the operation. All outputs return to their reset values; no done pulse is produced.
- Width rules:
  - Subtraction is implemented as a + ~b + 1.
  - The counter saturates logic at WIDTH-1 compare; it never wraps inside RUN.
  - WIDTH=2 must work: RUN lasts 2 cycles.

Decomposition:
- Shared package tt_addsub_pkg holds:
  - the state typedef (IDLE/RUN/DONE, 2-bit encoding);
  - localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- Sub-module fa_cell: purely combinational 1-bit full adder (a, b, cin -> s, cout). It has the same function as the existing NAND-network full adder and is instantiated once.
- FSM, counter and shift registers live in tt_serial_addsub.

Test Plan:
- WIDTH=8, add 0x5A+0x3C: start at E0 -> busy for 8 cycles, done pulse at E0+8; sum=0x96, carry_out=0, overflow=1.
- Add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0. Then sub 0x10-0x20 back-to-back (start during DONE) -> sum=0xF0, carry_out=0, overflow=0; done exactly 9 cycles after the first done.
- Sub 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1. Sub 0x33-0x33 -> sum=0x00, carry_out=1, overflow=0.
- Start 0x01+0x02, then pulse start with a=0xAA, b=0x55 at RUN cycle 3 -> ignored; result sum=0x03, single done pulse, busy width exactly 8.
- Assert rst_n=0 asynchronously mid-RUN (between edges) during 0x7F+0x01 -> busy/done/sum/carry_out/overflow=0 immediately; after release, no done until a new start; a new 0x7F+0x01 then gives sum=0x80, overflow=1.
- WIDTH=2 and WIDTH=32 builds run a random add/sub sweep against a reference model. done latency must equal WIDTH; sum, carry_out and overflow must match exactly.

Source files
------------

// File: rtl/tt_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package tt_addsub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder built from the classic nine-NAND network.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic n1, n2, n3, x1, n4, n5, n6;

    // Purely combinational NAND network: s = a^b^cin, cout = maj(a,b,cin).
    always_comb begin
        n1   = ~(a & b);
        n2   = ~(a & n1);
        n3   = ~(b & n1);
        x1   = ~(n2 & n3);
        n4   = ~(x1 & cin);
        n5   = ~(x1 & n4);
        n6   = ~(cin & n4);
        s    = ~(n5 & n6);
        cout = ~(n1 & n4);
    end

endmodule

// File: rtl/tt_serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell reused LSB-first, one bit per clock.
module tt_serial_addsub
    import tt_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, done_q;
    logic             fa_s, fa_c;

    fa_cell u_fa (
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Next-state logic: load on accepted start, shift one bit per RUN cycle, publish on last bit.
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    // Subtraction as a + ~b + 1: invert b, seed the carry with 1.
                    state_d = StRun;
                    sh_a_d  = a;
                    sh_b_d  = op_sub ? ~b : b;
                    carry_d = op_sub;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            StRun: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                carry_d = fa_c;
                if (cnt_q == CntLast) begin
                    // carry_q here is the carry into the MSB.
                    state_d = StDone;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = fa_c ^ carry_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; async reset clears everything and aborts any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy      = busy_q;
        done      = done_q;
        sum       = sum_q;
        carry_out = cout_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_tt_serial_addsub.sv
// Self-checking bench: directed WIDTH=8 cases plus a random sweep on WIDTH=2/8/32 instances.
module tb_tt_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        busy8, done8, co8, ov8;
    logic [7:0]  sum8;
    logic        busy2, done2, co2, ov2;
    logic [1:0]  sum2;
    logic        busy32, done32, co32, ov32;
    logic [31:0] sum32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tt_serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a[7:0]), .b(b[7:0]),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
    );

    tt_serial_addsub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a[1:0]), .b(b[1:0]),
        .busy(busy2), .done(done2), .sum(sum2), .carry_out(co2), .overflow(ov2)
    );

    tt_serial_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy32), .done(done32), .sum(sum32), .carry_out(co32), .overflow(ov32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, carry_out, sum} from plain arithmetic on w-bit operands.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic sub, input int w);
        longint unsigned mask, xa, ya, s, full;
        logic sx, sy, ss, co, ov;
        mask = (64'd1 << w) - 64'd1;
        xa = {32'd0, x} & mask;
        ya = {32'd0, y} & mask;
        if (!sub) begin
            full = xa + ya;
            s    = full & mask;
            co   = ((full >> w) & 64'd1) != 0;
        end else begin
            s  = (xa - ya) & mask;
            co = (xa >= ya);
        end
        sx = ((xa >> (w - 1)) & 64'd1) != 0;
        sy = ((ya >> (w - 1)) & 64'd1) != 0;
        ss = ((s >> (w - 1)) & 64'd1) != 0;
        ov = sub ? ((sx != sy) && (ss != sx)) : ((sx == sy) && (ss != sx));
        return {ov, co, s[31:0]};
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!(busy2 | busy8 | busy32 | done2 | done8 | done32)) break;
            @(posedge clk); #1;
        end
    endtask

    // One operation on all three instances; checks latency, pulse shape and results vs model.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic sub);
        int lat8, lat2, lat32, nb8, nd8;
        logic [33:0] m;
        wait_idle();
        a = ta; b = tbv; op_sub = sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat8 = -1; lat2 = -1; lat32 = -1; nb8 = 0; nd8 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy8) nb8++;
            @(posedge clk); #1;
            if (done8) begin
                nd8++;
                if (lat8 < 0) lat8 = c;
            end
            if (done2 && lat2 < 0) lat2 = c;
            if (done32 && lat32 < 0) lat32 = c;
        end
        chk("lat w8", lat8, 8);
        chk("lat w2", lat2, 2);
        chk("lat w32", lat32, 32);
        chk("busy width w8", nb8, 8);
        chk("done pulses w8", nd8, 1);
        m = model(ta, tbv, sub, 8);
        chk("w8 result", {ov8, co8, 24'd0, sum8}, m);
        m = model(ta, tbv, sub, 2);
        chk("w2 result", {ov2, co2, 30'd0, sum2}, m);
        m = model(ta, tbv, sub, 32);
        chk("w32 result", {ov32, co32, sum32}, m);
    endtask

    initial begin
        int c, nb, nd, lat;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("reset busy", busy8, 0);
        chk("reset done", done8, 0);
        chk("reset outs", {ov8, co8, sum8}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0x5A + 0x3C
        run_op(32'h5A, 32'h3C, 1'b0);
        chk("5a+3c sum", sum8, 8'h96);
        chk("5a+3c co", co8, 0);
        chk("5a+3c ov", ov8, 1);

        // 0xFF + 0x01, then back-to-back 0x10 - 0x20 started during DONE
        wait_idle();
        a = 32'hFF; b = 32'h01; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (!done8 && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("ff+01 lat", c, 8);
        chk("ff+01 sum", sum8, 8'h00);
        chk("ff+01 co", co8, 1);
        chk("ff+01 ov", ov8, 0);
        a = 32'h10; b = 32'h20; op_sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        while (!done8 && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("b2b done gap", c, 9);
        chk("10-20 sum", sum8, 8'hF0);
        chk("10-20 co", co8, 0);
        chk("10-20 ov", ov8, 0);

        // Subtraction corners
        run_op(32'h80, 32'h01, 1'b1);
        chk("80-01 sum", sum8, 8'h7F);
        chk("80-01 co", co8, 1);
        chk("80-01 ov", ov8, 1);
        run_op(32'h33, 32'h33, 1'b1);
        chk("33-33 sum", sum8, 8'h00);
        chk("33-33 co", co8, 1);
        chk("33-33 ov", ov8, 0);

        // Start pulse during RUN must be ignored
        wait_idle();
        a = 32'h01; b = 32'h02; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nb = 0; nd = 0; lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (busy8) nb++;
            if (k == 3) begin
                a = 32'hAA; b = 32'h55; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done8) begin
                nd++;
                if (lat < 0) lat = k;
            end
        end
        start = 1'b0;
        chk("ignore lat", lat, 8);
        chk("ignore busy width", nb, 8);
        chk("ignore done pulses", nd, 1);
        chk("ignore sum", sum8, 8'h03);
        chk("ignore co/ov", {co8, ov8}, 0);

        // Asynchronous reset mid-RUN
        wait_idle();
        a = 32'h7F; b = 32'h01; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy8, 0);
        chk("abort done", done8, 0);
        chk("abort outs", {ov8, co8, sum8}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) nd++;
        end
        chk("no done after abort", nd, 0);
        run_op(32'h7F, 32'h01, 1'b0);
        chk("7f+01 sum", sum8, 8'h80);
        chk("7f+01 co", co8, 0);
        chk("7f+01 ov", ov8, 1);

        // Random sweep across all widths
        repeat (20) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
